// File: rtl/image_xfer_ctrl.sv
`default_nettype none
// image_xfer_ctrl: byte-serial PC link that clears, downloads to and uploads from a word memory.
// Define IMAGE_XFER_CHECKSUM_EN to append an XOR checksum byte to each download/upload.
module image_xfer_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int BPW       = 4,
  parameter int DL_BASE   = 0,
  parameter int DL_WORDS  = 25344,
  parameter int UL_BASE   = 25344,
  parameter int UL_WORDS  = 25344,
  parameter int CLR_WORDS = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic [7:0]        tx_data,
  output logic              tx_stb,
  input  logic              tx_ack,
  input  logic [7:0]        rx_data,
  input  logic              rx_stb,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [8*BPW-1:0]  mem_dw,
  input  logic [8*BPW-1:0]  mem_dr,
  output logic              busy
);

  localparam logic [2:0] S_CLEAR      = 3'd0;
  localparam logic [2:0] S_IDLE       = 3'd1;
  localparam logic [2:0] S_TEST_REPLY = 3'd2;
  localparam logic [2:0] S_DL_RX      = 3'd3;
  localparam logic [2:0] S_DL_STORE   = 3'd4;
  localparam logic [2:0] S_UL_FETCH   = 3'd5;
  localparam logic [2:0] S_UL_TX      = 3'd6;
`ifdef IMAGE_XFER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM_TX    = 3'd7;
  localparam logic [2:0] S_DONE       = S_CSUM_TX;
`else
  localparam logic [2:0] S_DONE       = S_IDLE;
`endif

  localparam logic [7:0] CMD_TEST  = 8'h74;
  localparam logic [7:0] CMD_CLEAR = 8'h63;
  localparam logic [7:0] CMD_WRITE = 8'h77;
  localparam logic [7:0] CMD_READ  = 8'h72;
  localparam logic [7:0] TEST_ACK  = 8'h79;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] DL_FIRST  = ADDR_W'(DL_BASE);
  localparam logic [ADDR_W-1:0] DL_LAST   = ADDR_W'(DL_BASE + DL_WORDS - 1);
  localparam logic [ADDR_W-1:0] UL_FIRST  = ADDR_W'(UL_BASE);
  localparam logic [ADDR_W-1:0] UL_LAST   = ADDR_W'(UL_BASE + UL_WORDS - 1);
  localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(CLR_WORDS - 1);
  localparam logic [2:0]        LAST_LANE = 3'(BPW - 1);

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        lane;
  logic [8*BPW-1:0]  word_buf;

  assign mem_addr = addr;
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_CLEAR;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_CLEAR:      if (addr == CLR_LAST) next_state = S_IDLE;
      S_IDLE: begin
        if (rx_stb) begin
          case (rx_data)
            CMD_TEST:  next_state = S_TEST_REPLY;
            CMD_CLEAR: next_state = S_CLEAR;
            CMD_WRITE: next_state = S_DL_RX;
            CMD_READ:  next_state = S_UL_FETCH;
            default:   next_state = S_IDLE;
          endcase
        end
      end
      S_TEST_REPLY: if (tx_ack) next_state = S_IDLE;
      S_DL_RX:      if (rx_stb && lane == LAST_LANE) next_state = S_DL_STORE;
      S_DL_STORE:   next_state = (addr == DL_LAST) ? S_DONE : S_DL_RX;
      S_UL_FETCH:   next_state = S_UL_TX;
      S_UL_TX: begin
        if (tx_ack && lane == LAST_LANE)
          next_state = (addr == UL_LAST) ? S_DONE : S_UL_FETCH;
      end
`ifdef IMAGE_XFER_CHECKSUM_EN
      S_CSUM_TX:    if (tx_ack) next_state = S_IDLE;
`endif
      default:      next_state = S_CLEAR;
    endcase
  end

  // Address, lane index and assembly buffer; addr wraps naturally at ADDR_W bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr     <= '0;
      lane     <= '0;
      word_buf <= '0;
    end else begin
      case (state)
        S_CLEAR: addr <= addr + ADDR_ONE;
        S_IDLE: begin
          if (rx_stb) begin
            case (rx_data)
              CMD_CLEAR: addr <= '0;
              CMD_WRITE: begin addr <= DL_FIRST; lane <= '0; end
              CMD_READ:  begin addr <= UL_FIRST; lane <= '0; end
              default:   ;
            endcase
          end
        end
        S_DL_RX: begin
          if (rx_stb) begin
            for (int l = 0; l < BPW; l++)
              if (lane == 3'(l)) word_buf[8*l +: 8] <= rx_data;
            lane <= (lane == LAST_LANE) ? 3'd0 : lane + 3'd1;
          end
        end
        S_DL_STORE: if (addr != DL_LAST) addr <= addr + ADDR_ONE;
        S_UL_TX: begin
          if (tx_ack) begin
            if (lane == LAST_LANE) begin
              lane <= '0;
              if (addr != UL_LAST) addr <= addr + ADDR_ONE;
            end else begin
              lane <= lane + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IMAGE_XFER_CHECKSUM_EN
  logic [7:0] csum;
  logic       is_cmd;

  assign is_cmd = (rx_data == CMD_TEST) || (rx_data == CMD_CLEAR) ||
                  (rx_data == CMD_WRITE) || (rx_data == CMD_READ);

  always_ff @(posedge clk) begin
    if (reset)                                csum <= '0;
    else if (state == S_IDLE && rx_stb && is_cmd) csum <= '0;
    else if (state == S_DL_RX && rx_stb)      csum <= csum ^ rx_data;
    else if (state == S_UL_TX && tx_ack)      csum <= csum ^ tx_data;
  end
`endif

  always_comb begin
    tx_data = 8'h00;
    tx_stb  = 1'b0;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    mem_dw  = '0;
    case (state)
      S_CLEAR: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
      end
      S_TEST_REPLY: begin
        tx_data = TEST_ACK;
        tx_stb  = 1'b1;
      end
      S_DL_STORE: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
        mem_dw = word_buf;
      end
      S_UL_FETCH: mem_en = 1'b1;
      S_UL_TX: begin
        // Holding mem_en with a stable address keeps mem_dr valid for all lanes.
        mem_en = 1'b1;
        tx_stb = 1'b1;
        for (int l = 0; l < BPW; l++)
          if (lane == 3'(l)) tx_data = mem_dr[8*l +: 8];
      end
`ifdef IMAGE_XFER_CHECKSUM_EN
      S_CSUM_TX: begin
        tx_data = csum;
        tx_stb  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_image_xfer_ctrl.sv
`default_nettype none
// tb_image_xfer_ctrl: scoreboard bench; memory writes and accepted tx bytes are checked against queues.
module tb_image_xfer_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  tx_data;
  logic        tx_stb;
  logic        tx_ack;
  logic [7:0]  rx_data;
  logic        rx_stb;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [15:0] mem_dw;
  logic [15:0] mem_dr;
  logic        busy;

  image_xfer_ctrl #(
    .ADDR_W(4), .BPW(2), .DL_BASE(0), .DL_WORDS(2),
    .UL_BASE(0), .UL_WORDS(2), .CLR_WORDS(16)
  ) dut (
    .clk(clk), .reset(reset),
    .tx_data(tx_data), .tx_stb(tx_stb), .tx_ack(tx_ack),
    .rx_data(rx_data), .rx_stb(rx_stb),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_dw(mem_dw), .mem_dr(mem_dr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  int checks = 0;
  int errors = 0;
  int hold = 0;
  int last_hold = 0;
  int ack_delay = 1;
  logic [7:0] held;
  logic stable;
  logic [15:0] mem [16];

  // Synchronous-read memory with a garbage start so the clear pass is visible.
  initial for (int i = 0; i < 16; i++) mem[i] = 16'hA5A5;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we && !reset) mem[mem_addr] <= mem_dw;
      mem_dr <= mem[mem_addr];
    end
  end

  // PC side: acknowledge a byte once it has been presented for ack_delay cycles.
  always @(posedge clk) begin
    #1;
    tx_ack = tx_stb && (hold + 1 >= ack_delay);
  end

  always @(negedge clk) begin
    if (reset) begin
      hold = 0;
    end else begin
      if (mem_en && mem_we) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0h data=%04h required none", mem_addr, mem_dw);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          if (mem_addr !== e.a || mem_dw !== e.d) begin
            errors++;
            $display("FAIL mem_write got addr=%0h data=%04h required addr=%0h data=%04h",
                     mem_addr, mem_dw, e.a, e.d);
          end
        end
      end
      if (tx_stb) begin
        if (hold == 0) begin
          held = tx_data;
          stable = 1'b1;
        end else if (tx_data !== held) begin
          stable = 1'b0;
        end
        if (tx_ack) begin
          checks++;
          if (exp_tx.size() == 0) begin
            errors++;
            $display("FAIL unexpected_tx got %02h required none", tx_data);
          end else begin
            logic [7:0] eb;
            eb = exp_tx.pop_front();
            if (tx_data !== eb || !stable) begin
              errors++;
              $display("FAIL tx_byte got %02h stable=%0b required %02h stable=1", tx_data, stable, eb);
            end
          end
          last_hold = hold + 1;
          hold = 0;
        end else begin
          hold++;
        end
      end else begin
        hold = 0;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, want);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_stb  = 1'b1;
    @(posedge clk); #1;
    rx_stb  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy || exp_wr.size() != 0 || exp_tx.size() != 0) begin
      errors++;
      $display("FAIL %s busy=%0b pending_wr=%0d pending_tx=%0d required 0 0 0",
               name, busy, exp_wr.size(), exp_tx.size());
    end
  endtask

  task automatic push_clear();
    for (int i = 0; i < 16; i++) exp_wr.push_back('{a: 4'(i), d: 16'h0000});
  endtask

  task automatic reset_and_clear();
    int n;
    push_clear();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_tx_stb", 16'(tx_stb), 16'h0);
    check("rst_tx_data", 16'(tx_data), 16'h0);
    check("rst_addr", 16'(mem_addr), 16'h0);
    check("rst_busy", 16'(busy), 16'h1);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("clear_cycles", 16'(n), 16'd16);
    check("clear_done_busy", 16'(busy), 16'h0);
    check("clear_pending", 16'(exp_wr.size()), 16'h0);
  endtask

  initial begin
    int seen;
    reset   = 1'b1;
    rx_stb  = 1'b0;
    rx_data = 8'h00;
    tx_ack  = 1'b0;

    reset_and_clear();

    // Test reply held three cycles before acknowledge
    ack_delay = 3;
    exp_tx.push_back(8'h79);
    send_rx(8'h74);
    wait_idle("test_reply");
    check("test_reply_hold", 16'(last_hold), 16'd3);
    ack_delay = 1;

    // Unknown command ignored
    send_rx(8'h41);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || mem_en) seen++;
    end
    check("ignore_0x41", 16'(seen), 16'h0);

    // Download two words
    exp_wr.push_back('{a: 4'h0, d: 16'h2211});
    exp_wr.push_back('{a: 4'h1, d: 16'h4433});
`ifdef IMAGE_XFER_CHECKSUM_EN
    exp_tx.push_back(8'h44);
`endif
    send_rx(8'h77);
    send_rx(8'h11);
    send_rx(8'h22);
    send_rx(8'h33);
    send_rx(8'h44);
    wait_idle("download");

    // Upload, ack every cycle
    exp_tx.push_back(8'h11);
    exp_tx.push_back(8'h22);
    exp_tx.push_back(8'h33);
    exp_tx.push_back(8'h44);
`ifdef IMAGE_XFER_CHECKSUM_EN
    exp_tx.push_back(8'h44);
`endif
    send_rx(8'h72);
    wait_idle("upload");

    // Upload with slow acks and stray commands arriving mid-transfer
    ack_delay = 4;
    exp_tx.push_back(8'h11);
    exp_tx.push_back(8'h22);
    exp_tx.push_back(8'h33);
    exp_tx.push_back(8'h44);
`ifdef IMAGE_XFER_CHECKSUM_EN
    exp_tx.push_back(8'h44);
`endif
    send_rx(8'h72);
    send_rx(8'h77);
    send_rx(8'h63);
    send_rx(8'h74);
    wait_idle("upload_rx_noise");
    ack_delay = 1;

    // Reset in the middle of a download restarts the clear pass
    send_rx(8'h77);
    send_rx(8'h11);
    reset_and_clear();
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h00);
`ifdef IMAGE_XFER_CHECKSUM_EN
    exp_tx.push_back(8'h00);
`endif
    send_rx(8'h72);
    wait_idle("upload_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/image_xfer_ctrl.md
IMAGE_XFER_CTRL -- requirements
Module: image_xfer_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory word-address width.
REQ-002 SHALL have parameter BPW, default 4, bytes per memory word (1..8); data width DW = 8*BPW.
REQ-003 SHALL have parameters DL_BASE 0, DL_WORDS 25344, UL_BASE 25344, UL_WORDS 25344: start address and word count of the download and upload regions.
REQ-004 SHALL have parameter CLR_WORDS, default 2**ADDR_W, words zeroed from address 0 by a clear pass.
REQ-005 Ports, in order:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- tx_data  out  8  byte to PC
- tx_stb  out  1  tx_data valid
- tx_ack  in  1  byte accepted this cycle
- rx_data  in  8  byte from PC
- rx_stb  in  1  rx_data valid, single cycle
- mem_en  out  1  memory enable
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word address
- mem_dw  out  DW  write data
- mem_dr  in  DW  read data, one cycle after mem_en
- busy  out  1  high in every state except IDLE

Function
REQ-006 States SHALL be: CLEAR, IDLE, TEST_REPLY, DL_RX, DL_STORE, UL_FETCH, UL_TX, CSUM_TX.
REQ-007 IDLE SHALL decode rx bytes on rx_stb: 't' (0x74) -> TEST_REPLY; 'c' (0x63) -> CLEAR with addr 0; 'w' (0x77) -> DL_RX with addr DL_BASE, byte index 0; 'r' (0x72) -> UL_FETCH with addr UL_BASE; any other byte SHALL be ignored.
REQ-008 TEST_REPLY SHALL drive tx_data=0x79, tx_stb=1 until tx_ack, then enter IDLE.
REQ-009 CLEAR SHALL assert mem_en=mem_we=1, mem_dw=0 every cycle, incrementing addr from 0 to CLR_WORDS-1, then enter IDLE; CLR_WORDS writes SHALL take exactly CLR_WORDS cycles.
REQ-010 DL_RX SHALL place each received byte at word byte lane index (little-endian, lane 0 first); after lane BPW-1 it SHALL enter DL_STORE.
REQ-011 DL_STORE SHALL assert mem_en=mem_we=1 for one cycle with the assembled word; after word DL_WORDS-1 it SHALL go to CSUM_TX if enabled, else IDLE; otherwise addr+1 and DL_RX.
REQ-012 UL_FETCH SHALL assert mem_en for one cycle; UL_TX SHALL hold mem_en=1 and addr stable, sending lanes 0..BPW-1 of mem_dr, each held on tx_data with tx_stb=1 until tx_ack.
REQ-013 After lane BPW-1 of word UL_WORDS-1, UL_TX SHALL go to CSUM_TX if enabled, else IDLE; otherwise addr+1 and UL_FETCH.
REQ-014 rx_stb outside IDLE and DL_RX SHALL be discarded without effect.
REQ-015 Address arithmetic SHALL be ADDR_W-bit, wrapping modulo 2**ADDR_W if base+count exceeds range.
REQ-016 tx_stb SHALL be 0 and mem_we SHALL be 0 in every state not named above as driving them.

Reset
REQ-017 On reset: state CLEAR, addr 0, byte index 0, data buffer 0, checksum 0; tx_stb=0, tx_data=0.
REQ-018 Reset asserted mid-transfer SHALL abort it; the next cycle begins a full clear pass.
REQ-019 After reset release the block SHALL perform one full clear pass before accepting commands.

Configuration
REQ-020 Macro IMAGE_XFER_CHECKSUM_EN defined: an 8-bit XOR of every byte received (download) or sent (upload) SHALL be cleared on command decode and transmitted by CSUM_TX (tx_stb until tx_ack) before IDLE.
REQ-021 Macro undefined: CSUM_TX and checksum register SHALL not exist; transfers end directly in IDLE.

Verification (ADDR_W=4, BPW=2, DL_BASE=0, DL_WORDS=2, UL_BASE=0, UL_WORDS=2, CLR_WORDS=16)
REQ-022 Reset 1 cycle -> mem_we=1 for exactly 16 cycles, addr 0..15, mem_dw=0, then busy=0.
REQ-023 rx 0x74, tx_ack after 3 cycles -> tx_data=0x79 held 3 cycles, then IDLE.
REQ-024 rx 0x77,0x11,0x22,0x33,0x44 -> writes 0x2211 @0, 0x4433 @1; with macro, tx 0x44 (XOR) then IDLE.
REQ-025 Then rx 0x72, tx_ack each cycle -> tx 0x11,0x22,0x33,0x44; with macro, trailing 0x44.
REQ-026 rx 0x41 in IDLE, and rx bytes during UL_TX -> no state change, no memory access.
REQ-027 Reset asserted after 0x77,0x11 -> clear pass restarts at addr 0; next 'r' returns 0x00 bytes.
